uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART receiver and the hex multiplier datapath.
//  Parses ASCII lines "<hexA>*<hexB>\r" from the byte stream and launches the multiplier.
//  Returns the product as fixed-width uppercase hex, then CR LF, through the UART transmitter.
//  Sole owner of the multiplier and the transmitter; no other requester.
// PARAMETERS
//  OPW   16  operand width in bits; multiple of 4. Max digits per operand ND = OPW/4.
//  PW    2*OPW  product width (derived localparam, not overridable). Output digits = PW/4.
// PORTS
//  clk        in   1      system clock, single domain
//  reset      in   1      asynchronous, active-high reset
//  rx_data    in   8      received byte, valid when rx_done=1
//  rx_done    in   1      1-cycle strobe, byte received
//  mul_a      out  OPW    operand A, held stable from mul_start until mul_done
//  mul_b      out  OPW    operand B, same hold rule
//  mul_start  out  1      1-cycle pulse, launch multiply
//  mul_done   in   1      1-cycle pulse, mul_p valid this cycle
//  mul_p      in   PW     product
//  tx_data    out  8      byte to transmit, held until tx_done
//  tx_start   out  1      1-cycle pulse, launch transmission of tx_data
//  tx_done    in   1      1-cycle pulse, transmitter finished the byte
//  busy       out  1      high in every state except GET_A/GET_B
//  err        out  1      1-cycle pulse on any parse error
// BEHAVIOUR
//  Reset: all outputs 0, operand/product/digit regs 0, state GET_A.
//  GET_A: hex char (0-9, A-F, a-f) -> acc_a = {acc_a[OPW-5:0], nibble}, cnt++. '*' with cnt>=1 -> GET_B, cnt=0.
//  GET_B: same accumulation into acc_b. CR (0x0D) with cnt>=1 -> MUL_GO.
//  Parse errors (-> ERR): non-hex char other than expected delimiter; (ND+1)th digit; delimiter with cnt=0; '*' in GET_B.
//  LF (0x0A) and space (0x20) are ignored in GET_A/GET_B without error.
//  MUL_GO: mul_start=1 for exactly one cycle -> WAIT_MUL. CR strobe in cycle n => mul_start in cycle n+1.
//  WAIT_MUL: on mul_done latch mul_p -> SEND_HEX, digit idx=PW/4-1 (MSB nibble first, leading zeros kept).
//  SEND_*: each byte: tx_data set and tx_start pulsed in the same cycle, then wait tx_done; next tx_start no earlier than cycle after tx_done.
//  SEND_HEX -> SEND_CR (0x0D) -> SEND_LF (0x0A) -> GET_A; acc_a, acc_b, cnt cleared.
//  ERR: err pulse on entry cycle; transmit '?' (0x3F), then CR, LF; return to GET_A cleared.
//  rx_done while busy=1: byte dropped silently, no state change, no err.
//  mul_done outside WAIT_MUL, tx_done outside SEND_*/ERR: ignored.
//  Reset asserted mid-operation: immediate return to reset values; a pending transmission is abandoned.
//  Arithmetic: nibble decode is unsigned; output nibble 0-9 -> 0x30+n, 10-15 -> 0x37+n (uppercase only).
// CONFIGURATION
//  UART_CMD_ECHO_EN defined: each accepted or ignored byte in GET_A/GET_B is echoed via tx
//   (tx_start in the cycle after rx_done); bytes arriving during the echo are dropped; busy=1 while echoing.
//  Not defined: no echo; the transmitter is used only for results and errors.
// STRUCTURE
//  Package uart_cmd_pkg: ASCII constants (CR, LF, STAR, QMARK, SPACE), state encoding localparams.
//  Sub-module hex_ascii_conv (combinational): ascii->{is_hex, nibble}, nibble->ascii. Instantiated twice.
//  Remaining FSM/datapath flat in this module.
// TESTING
//  "1A*2\r" (OPW=16) -> mul_a=0x001A, mul_b=0x0002; mul_done p=0x34 -> tx "00000034\r\n", no err.
//  "ffff*FFFF\r" -> mul_a=mul_b=0xFFFF; p=0xFFFE0001 -> tx "FFFE0001\r\n".
//  "12345*1\r" -> err pulse on 5th digit, tx "?\r\n", no mul_start; next "3*3\r" -> "00000009\r\n".
//  "*5\r", "5\r", "1G*2\r" -> each: err pulse, tx "?\r\n", no mul_start.
//  Bytes injected during WAIT_MUL and SEND_HEX -> dropped; result unchanged; reset during SEND_HEX -> outputs 0, GET_A.
//  With UART_CMD_ECHO_EN: "2*3\r" -> tx "2*3\r" echoed, then "00000006\r\n".

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// rtl/uart_cmd_ctrl_pkg.sv - ASCII constants and state encoding for the UART command sequencer
package uart_cmd_pkg;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_STAR  = 8'h2A;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [3:0] {
      ST_GET_A    = 4'd0,
      ST_GET_B    = 4'd1,
      ST_MUL_GO   = 4'd2,
      ST_WAIT_MUL = 4'd3,
      ST_SEND_HEX = 4'd4,
      ST_SEND_CR  = 4'd5,
      ST_SEND_LF  = 4'd6,
      ST_ERR      = 4'd7,
      ST_ECHO     = 4'd8
   } state_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - receiver, multiplier and transmitter handshakes of the command sequencer
interface uart_cmd_ctrl_if #(
   parameter int OPW = 16
);
   localparam int PW = 2 * OPW;

   logic [7:0]     rx_data;
   logic           rx_done;
   logic [OPW-1:0] mul_a;
   logic [OPW-1:0] mul_b;
   logic           mul_start;
   logic           mul_done;
   logic [PW-1:0]  mul_p;
   logic [7:0]     tx_data;
   logic           tx_start;
   logic           tx_done;
   logic           busy;
   logic           err;

   // Sequencer side
   modport master (
      input  rx_data, rx_done, mul_done, mul_p, tx_done,
      output mul_a, mul_b, mul_start, tx_data, tx_start, busy, err
   );

   // Receiver / multiplier / transmitter side
   modport slave (
      output rx_data, rx_done, mul_done, mul_p, tx_done,
      input  mul_a, mul_b, mul_start, tx_data, tx_start, busy, err
   );

endinterface

// File: rtl/hex_ascii_conv.sv
// rtl/hex_ascii_conv.sv - combinational ASCII hex digit decoder and uppercase nibble encoder
module hex_ascii_conv (
   input  logic [7:0] ascii_i,
   output logic       is_hex_o,
   output logic [3:0] nibble_o,
   input  logic [3:0] nibble_i,
   output logic [7:0] ascii_o
);

   // Decode 0-9, A-F, a-f; letters share the low nibble 1..6 in both cases
   always_comb begin
      is_hex_o = 1'b0;
      nibble_o = 4'd0;
      if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
         is_hex_o = 1'b1;
         nibble_o = ascii_i[3:0];
      end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                   (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
         is_hex_o = 1'b1;
         nibble_o = ascii_i[3:0] + 4'd9;
      end
   end

   // Encode a nibble as an uppercase hex character
   always_comb begin
      if (nibble_i < 4'd10) begin
         ascii_o = 8'h30 + {4'd0, nibble_i};
      end else begin
         ascii_o = 8'h37 + {4'd0, nibble_i};
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - parses "<hexA>*<hexB>\r", runs the multiplier, sends the product in hex (echo option: UART_CMD_ECHO_EN)
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int OPW = 16
) (
   input  logic             clk,
   input  logic             reset,
   uart_cmd_ctrl_if.master  bus
);

   localparam int PW   = 2 * OPW;
   localparam int ND   = OPW / 4;
   localparam int NDIG = PW / 4;
   localparam int CW   = $clog2(ND + 1);
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t         state_q, state_d;
   logic [OPW-1:0] acc_a_q, acc_a_d;
   logic [OPW-1:0] acc_b_q, acc_b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [PW-1:0]  prod_q, prod_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           tx_pend_q, tx_pend_d;
`ifdef UART_CMD_ECHO_EN
   logic [7:0]     echo_q, echo_d;
   state_t         ret_q, ret_d;
`endif

   logic           rx_is_hex;
   logic [3:0]     rx_nib;
   logic [3:0]     hex_nib;
   logic [7:0]     hex_char;
   logic           unused_rx_enc;
   logic           unused_tx_is_hex;
   logic [3:0]     unused_tx_nib;
   logic [7:0]     unused_rx_char;

   assign hex_nib       = prod_q[{idx_q, 2'b00} +: 4];
   assign unused_rx_enc = ^unused_rx_char;

   hex_ascii_conv u_rx_conv (
      .ascii_i  (bus.rx_data),
      .is_hex_o (rx_is_hex),
      .nibble_o (rx_nib),
      .nibble_i (4'd0),
      .ascii_o  (unused_rx_char)
   );

   hex_ascii_conv u_tx_conv (
      .ascii_i  (8'h00),
      .is_hex_o (unused_tx_is_hex),
      .nibble_o (unused_tx_nib),
      .nibble_i (hex_nib),
      .ascii_o  (hex_char)
   );

   assign bus.mul_a = acc_a_q;
   assign bus.mul_b = acc_b_q;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_GET_A;
         acc_a_q   <= '0;
         acc_b_q   <= '0;
         cnt_q     <= '0;
         prod_q    <= '0;
         idx_q     <= '0;
         tx_pend_q <= 1'b0;
`ifdef UART_CMD_ECHO_EN
         echo_q    <= 8'h00;
         ret_q     <= ST_GET_A;
`endif
      end else begin
         state_q   <= state_d;
         acc_a_q   <= acc_a_d;
         acc_b_q   <= acc_b_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         idx_q     <= idx_d;
         tx_pend_q <= tx_pend_d;
`ifdef UART_CMD_ECHO_EN
         echo_q    <= echo_d;
         ret_q     <= ret_d;
`endif
      end
   end

   // Line parser, multiplier launch and byte-by-byte transmit sequencing
   always_comb begin
      state_t nxt;
      logic   sending;

      nxt           = state_q;
      sending       = 1'b0;
      state_d       = state_q;
      acc_a_d       = acc_a_q;
      acc_b_d       = acc_b_q;
      cnt_d         = cnt_q;
      prod_d        = prod_q;
      idx_d         = idx_q;
      tx_pend_d     = tx_pend_q;
`ifdef UART_CMD_ECHO_EN
      echo_d        = echo_q;
      ret_d         = ret_q;
`endif
      bus.mul_start = 1'b0;
      bus.tx_start  = 1'b0;
      bus.tx_data   = 8'h00;
      bus.busy      = 1'b1;
      bus.err       = (state_q == ST_ERR) && !tx_pend_q;

      case (state_q)
         ST_GET_A, ST_GET_B: begin
            bus.busy = 1'b0;
            if (bus.rx_done) begin
               if (rx_is_hex) begin
                  if (cnt_q == CW'(ND)) begin
                     nxt = ST_ERR;
                  end else begin
                     if (state_q == ST_GET_A) begin
                        acc_a_d = {acc_a_q[OPW-5:0], rx_nib};
                     end else begin
                        acc_b_d = {acc_b_q[OPW-5:0], rx_nib};
                     end
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (bus.rx_data == ASCII_LF || bus.rx_data == ASCII_SPACE) begin
                  nxt = state_q;
               end else if (state_q == ST_GET_A && bus.rx_data == ASCII_STAR && cnt_q != '0) begin
                  nxt   = ST_GET_B;
                  cnt_d = '0;
               end else if (state_q == ST_GET_B && bus.rx_data == ASCII_CR && cnt_q != '0) begin
                  nxt = ST_MUL_GO;
               end else begin
                  nxt = ST_ERR;
               end
`ifdef UART_CMD_ECHO_EN
               if (nxt != ST_ERR) begin
                  echo_d  = bus.rx_data;
                  ret_d   = nxt;
                  state_d = ST_ECHO;
               end else begin
                  state_d = nxt;
               end
`else
               state_d = nxt;
`endif
            end
         end
         ST_MUL_GO: begin
            bus.mul_start = 1'b1;
            state_d       = ST_WAIT_MUL;
         end
         ST_WAIT_MUL: begin
            if (bus.mul_done) begin
               prod_d    = bus.mul_p;
               idx_d     = IW'(NDIG - 1);
               tx_pend_d = 1'b0;
               state_d   = ST_SEND_HEX;
            end
         end
         ST_SEND_HEX: begin
            sending     = 1'b1;
            bus.tx_data = hex_char;
         end
         ST_SEND_CR: begin
            sending     = 1'b1;
            bus.tx_data = ASCII_CR;
         end
         ST_SEND_LF: begin
            sending     = 1'b1;
            bus.tx_data = ASCII_LF;
         end
         ST_ERR: begin
            sending     = 1'b1;
            bus.tx_data = ASCII_QMARK;
         end
`ifdef UART_CMD_ECHO_EN
         ST_ECHO: begin
            sending     = 1'b1;
            bus.tx_data = echo_q;
         end
`endif
         default: begin
            state_d = ST_GET_A;
         end
      endcase

      // A byte is launched once per state visit; the next launch waits for the cycle after tx_done
      if (sending) begin
         if (!tx_pend_q) begin
            bus.tx_start = 1'b1;
            tx_pend_d    = 1'b1;
         end else if (bus.tx_done) begin
            tx_pend_d = 1'b0;
            case (state_q)
               ST_SEND_HEX: begin
                  if (idx_q == '0) begin
                     state_d = ST_SEND_CR;
                  end else begin
                     idx_d = idx_q - 1'b1;
                  end
               end
               ST_SEND_CR: state_d = ST_SEND_LF;
               ST_SEND_LF: begin
                  state_d = ST_GET_A;
                  acc_a_d = '0;
                  acc_b_d = '0;
                  cnt_d   = '0;
               end
               ST_ERR: state_d = ST_SEND_CR;
`ifdef UART_CMD_ECHO_EN
               ST_ECHO: state_d = ret_q;
`endif
               default: state_d = ST_GET_A;
            endcase
         end
      end
   end

endmodule
